bram_save_ctrl: RTL

Sequences cartridge backup-RAM transfers between the system's BRAM port and the HPS SD-image interface. It arbitrates four transfer triggers: post-download load, OSD load, OSD save and autosave-on-OSD-open. It then walks the sector handshake from LBA 0 to SECTORS-1. It sits between `hps_io` (sd_* and img_* signals) and `system` (BRAM_CHANGE). Its `bk_loading` output holds the console in reset during loads.

---
 rtl/bram_save_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/bram_save_ctrl.sv
// Backup-RAM transfer sequencer: arbitrates load/save triggers and walks the
// HPS sector handshake from LBA 0 to SECTORS-1.
module bram_save_ctrl #(
  parameter int          SECTORS = 128,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        downloading,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  input  logic        img_readonly,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave_en,
  input  logic        osd_open,
  input  logic        bram_change,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_loading,
  output logic        busy,
  output logic        sav_pending,
  output logic        err
);

  localparam int              LW       = $clog2(SECTORS);
  localparam logic [LW-1:0]   LBA_LAST = LW'(SECTORS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam int E_DL  = 0;
  localparam int E_LD  = 1;
  localparam int E_SV  = 2;
  localparam int E_AS  = 3;
  localparam int E_ACK = 4;

  logic [1:0]    state_reg, state_next;
  logic [LW-1:0] lba_reg, lba_next;
  logic          rd_reg, rd_next;
  logic          wr_reg, wr_next;
  logic          loading_reg, loading_next;
  logic [23:0]   timer_reg, timer_next;
  logic          err_reg, err_next;
  logic          bk_ena_reg, bk_ena_next;
  logic          pending_reg, pending_next;

  logic       autosave_term;
  logic [4:0] edge_in;
  logic [4:0] edge_prev;

  assign autosave_term = pending_reg & osd_open & autosave_en;
  assign edge_in       = {sd_ack, autosave_term, save_req, load_req, downloading};

  // Edge-detect history always tracks its input, reset or not, so a level
  // already high when reset releases never looks like an edge.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_edge
      logic prev_reg;
      always_ff @(posedge clk_sys) begin
        prev_reg <= edge_in[gi];
      end
      assign edge_prev[gi] = prev_reg;
    end
  endgenerate

  logic dl_rise;
  logic trig_dl, trig_ld, trig_sv, trig_as;
  logic trig_any, trig_load, start;
  logic ack_rise, ack_fall;
  logic mount_ok;

  assign dl_rise   = downloading & ~edge_prev[E_DL];
  assign trig_dl   = ~downloading & edge_prev[E_DL];
  assign trig_ld   = load_req & ~edge_prev[E_LD];
  assign trig_sv   = save_req & ~edge_prev[E_SV];
  assign trig_as   = autosave_term & ~edge_prev[E_AS];
  assign ack_rise  = sd_ack & ~edge_prev[E_ACK];
  assign ack_fall  = ~sd_ack & edge_prev[E_ACK];

  assign trig_any  = trig_dl | trig_ld | trig_sv | trig_as;
  // Both load sources outrank both save sources, so direction reduces to this.
  assign trig_load = trig_dl | trig_ld;
  assign start     = (state_reg == ST_IDLE) & bk_ena_reg & trig_any;

  assign mount_ok  = downloading & img_mounted & (img_size != 64'd0) & ~img_readonly;

  always_comb begin
    bk_ena_next = bk_ena_reg;
    if (mount_ok) begin
      bk_ena_next = 1'b1;
    end else if (dl_rise) begin
      bk_ena_next = 1'b0;
    end

    pending_next = pending_reg;
    if (start) begin
      pending_next = 1'b0;
    end else if (bram_change & ~osd_open) begin
      pending_next = 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lba_next     = lba_reg;
    rd_next      = rd_reg;
    wr_next      = wr_reg;
    loading_next = loading_reg;
    timer_next   = timer_reg;
    err_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          lba_next     = '0;
          loading_next = trig_load;
          rd_next      = trig_load;
          wr_next      = ~trig_load;
          timer_next   = '0;
          state_next   = ST_REQ;
        end
      end

      ST_REQ: begin
        if (ack_rise) begin
          rd_next    = 1'b0;
          wr_next    = 1'b0;
          state_next = ST_XFER;
        end else if (timer_reg == TIMEOUT) begin
          rd_next      = 1'b0;
          wr_next      = 1'b0;
          loading_next = 1'b0;
          err_next     = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          timer_next = timer_reg + 24'd1;
        end
      end

      ST_XFER: begin
        if (ack_fall) begin
          if (lba_reg == LBA_LAST) begin
            loading_next = 1'b0;
            state_next   = ST_IDLE;
          end else begin
            lba_next   = lba_reg + LW'(1);
            rd_next    = loading_reg;
            wr_next    = ~loading_reg;
            timer_next = '0;
            state_next = ST_REQ;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      lba_reg     <= '0;
      rd_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      loading_reg <= 1'b0;
      timer_reg   <= '0;
      err_reg     <= 1'b0;
      bk_ena_reg  <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lba_reg     <= lba_next;
      rd_reg      <= rd_next;
      wr_reg      <= wr_next;
      loading_reg <= loading_next;
      timer_reg   <= timer_next;
      err_reg     <= err_next;
      bk_ena_reg  <= bk_ena_next;
      pending_reg <= pending_next;
    end
  end

  assign sd_lba      = {{(32 - LW){1'b0}}, lba_reg};
  assign sd_rd       = rd_reg;
  assign sd_wr       = wr_reg;
  assign bk_ena      = bk_ena_reg;
  assign bk_loading  = loading_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign sav_pending = pending_reg;
  assign err         = err_reg;

endmodule
